jk_cmd_seq: RTL and testbench
=============================

Name: jk_cmd_seq

Overview:
- Command sequencer directly upstream of the team's JK flip-flop stage.
- Accepts JK operations (hold / clear / set / toggle), each with a repeat count, over a valid/ready handshake, and buffers them in a small FIFO.
- Drives registered j/k outputs into the downstream flip-flop, one operation per clock per repeat.
- Maintains q_pred, a shadow model of the flip-flop's q, so control logic can read the expected state without a feedback path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 4, width of the repeat count; max repeat is 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high; shared with the downstream JK flip-flop.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command; equals !full.
- cmd_op  in  2  00 hold, 01 clear, 10 set, 11 toggle (same {j,k} encoding as the flip-flop).
- cmd_cnt  in  CNT_W  number of consecutive issue cycles.
- j  out  1  registered J to the flip-flop.
- k  out  1  registered K to the flip-flop.
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- q_pred  out  1  predicted flip-flop q.

Behaviour:
- Reset (sync, rst=1 at an edge): FIFO flushed; FSM=IDLE. Outputs j=0, k=0, done=0, busy=0, q_pred=0, cmd_ready=1.
- rst overrides any in-flight command or push in the same cycle.
- Push: cmd_valid && cmd_ready at an edge writes {cmd_op, cmd_cnt}.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle; no push-through-full.
  - Push and pop in the same cycle are otherwise legal; occupancy is unchanged.
- FSM states: IDLE, ISSUE.
- IDLE:
  - j=k=0.
  - If FIFO is non-empty at an edge: pop the head; load {j,k}=op; rem=cnt-1; go to ISSUE.
- cnt==0 command: popped, no issue cycles; j=k stay 0; done pulses in the cycle after the pop; FSM stays IDLE.
- ISSUE:
  - {j,k} hold the op for exactly cnt cycles.
  - While rem != 0: decrement rem at each edge.
  - At rem==0 (the last issue cycle):
    - done=1 in that cycle.
    - At the next edge, if FIFO is non-empty, pop and load the next command with no bubble (remain in ISSUE).
    - Otherwise go to IDLE with j=k=0.
- Latency: push at edge E0 into an empty FIFO with FSM IDLE → j/k valid after E1. Minimum command-to-output latency is 1 cycle.
- q_pred update at every edge, using the current j,k: 00 keep, 01 →0, 10 →1, 11 invert. It therefore equals the downstream q after each edge.
- busy is combinational from FSM state and FIFO empty.
- Hold op (00) still consumes cnt cycles; it serves as a timed delay.
- Pointer wrap: DEPTH-power-of-two pointers with one extra bit for full/empty.

Optional Feature:
- Macro: JKSEQ_CHECK_EN.
- Defined:
  - Adds input q_fb (1 bit, downstream q) and output mismatch (1 bit).
  - mismatch sets when q_fb != q_pred in any cycle starting with the first cycle after rst deasserts.
  - mismatch is sticky until rst; its reset value is 0.
- Undefined: neither port exists; no comparison logic.

Decomposition:
- Package jk_seq_pkg:
  - op encodings OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TGL=2'b11;
  - state enum {ST_IDLE, ST_ISSUE};
  - a helper function computing the next q from (q, j, k).
- Sub-module jk_cmd_fifo: synchronous FIFO parameterised by DEPTH and width 2+CNT_W. Ports: push, pop, wdata, rdata, full, empty.

Test Plan:
- Reset mid-command: push {10,cnt=5}; assert rst in the 3rd issue cycle → next cycle j=k=0, q_pred=0, busy=0, cmd_ready=1.
- Single set: push {10,3} → j=1,k=0 for 3 cycles starting 1 cycle after push; done on the 3rd; q_pred=1 afterwards.
- Back-to-back: push {11,4} then {01,2} → toggle 4 cycles (q_pred 1,0,1,0 after each), then clear 2 cycles with no bubble; done pulses twice.
- Full FIFO: push 4 commands of cnt=15 while the first is issuing → cmd_ready=0 once 4 are queued; the 5th is not accepted until a pop; all commands are issued in order.
- Zero count: push {11,0} → no j/k activity; done pulses once; q_pred unchanged.
- With JKSEQ_CHECK_EN: drive q_fb from a model flip-flop → mismatch stays 0. Force q_fb inverted for one cycle → mismatch=1 and stays 1 until rst.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK command sequencer: op encodings, FSM states,
// and the JK next-state rule used to predict the downstream flip-flop.
package jk_seq_pkg;

  localparam int unsigned OP_W = 2;

  // {j,k} encodings, identical to the downstream flip-flop inputs
  localparam logic [OP_W-1:0] OP_HOLD = 2'b00;
  localparam logic [OP_W-1:0] OP_CLR  = 2'b01;
  localparam logic [OP_W-1:0] OP_SET  = 2'b10;
  localparam logic [OP_W-1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Next q of a JK flip-flop given current q and inputs
  function automatic logic jk_next_q(input logic q, input logic j, input logic k);
    logic nq;
    nq = q;
    case ({j, k})
      OP_HOLD: nq = q;
      OP_CLR:  nq = 1'b0;
      OP_SET:  nq = 1'b1;
      OP_TGL:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO for queued JK commands; pointers carry one extra wrap bit
// to tell full from empty. Push is refused when full, even with a same-cycle pop.
module jk_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: queues {op,cnt} commands and drives registered j/k to
// the downstream JK flip-flop for cnt consecutive cycles each, back to back.
// q_pred shadows the flip-flop's q. Optional macro JKSEQ_CHECK_EN adds q_fb
// input and a sticky mismatch flag comparing q_fb with q_pred.
module jk_cmd_seq
  import jk_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             j,
  output logic             k,
  output logic             done,
  output logic             busy,
  output logic             q_pred
`ifdef JKSEQ_CHECK_EN
  ,
  input  logic             q_fb,
  output logic             mismatch
`endif
);

  localparam int unsigned ENT_W = OP_W + CNT_W;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_n;
  logic             j_n;
  logic             k_n;
  logic             done_n;
  logic             load;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] rdata;
  logic [OP_W-1:0]  head_op;
  logic [CNT_W-1:0] head_cnt;

  assign cmd_ready           = !full;
  assign push                = cmd_valid && cmd_ready;
  assign wdata               = {cmd_op, cmd_cnt};
  assign {head_op, head_cnt} = rdata;
  assign busy                = (state != ST_IDLE) || !empty;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // State, remaining count and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rem   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      j     <= j_n;
      k     <= k_n;
      done  <= done_n;
    end
  end

  // Next state: keep issuing while rem != 0, otherwise load the FIFO head
  always_comb begin
    state_n = state;
    rem_n   = rem;
    j_n     = 1'b0;
    k_n     = 1'b0;
    done_n  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;

    case (state)
      ST_ISSUE: begin
        if (rem != '0) begin
          rem_n  = rem - CNT_W'(1);
          j_n    = j;
          k_n    = k;
          done_n = (rem == CNT_W'(1));
        end else begin
          load = 1'b1;
        end
      end
      default: load = 1'b1;
    endcase

    if (load) begin
      if (empty) begin
        state_n = ST_IDLE;
      end else begin
        pop = 1'b1;
        if (head_cnt == '0) begin
          // zero-count command retires immediately without issue cycles
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n    = ST_ISSUE;
          {j_n, k_n} = head_op;
          rem_n      = head_cnt - CNT_W'(1);
          done_n     = (head_cnt == CNT_W'(1));
        end
      end
    end
  end

  // Shadow of the downstream flip-flop, advanced with the j/k it sees
  always_ff @(posedge clk) begin
    if (rst) q_pred <= 1'b0;
    else     q_pred <= jk_next_q(q_pred, j, k);
  end

`ifdef JKSEQ_CHECK_EN
  // Sticky flag for any divergence between real and predicted q
  always_ff @(posedge clk) begin
    if (rst)                  mismatch <= 1'b0;
    else if (q_fb != q_pred)  mismatch <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: vector table, directed multi-cycle sequences, and
// random traffic checked against a queue-based reference model.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             j, k, done, busy, q_pred;
`ifdef JKSEQ_CHECK_EN
  logic             q_fb;
  logic             mismatch;
  logic             qff;
  logic             inj = 1'b0;
`endif

  int nchk = 0;
  int nerr = 0;
  int done_seen = 0;
  logic hs;

  always #5 clk = ~clk;

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .j         (j),
    .k         (k),
    .done      (done),
    .busy      (busy),
    .q_pred    (q_pred)
`ifdef JKSEQ_CHECK_EN
    ,
    .q_fb      (q_fb),
    .mismatch  (mismatch)
`endif
  );

`ifdef JKSEQ_CHECK_EN
  // stand-in downstream JK flip-flop
  always @(posedge clk) begin
    if (rst) qff <= 1'b0;
    else case ({j, k})
      2'b01: qff <= 1'b0;
      2'b10: qff <= 1'b1;
      2'b11: qff <= ~qff;
      default: qff <= qff;
    endcase
  end
  assign q_fb = qff ^ inj;
`endif

  // ---------------- reference model ----------------
  typedef struct packed { logic [1:0] op; logic [CNT_W-1:0] cnt; } cmd_t;
  cmd_t mq[$];
  int   left = 0;       // issue cycles still owed by the current command, incl. this one
  logic mj = 1'b0, mk = 1'b0, md = 1'b0, mqp = 1'b0;

  task automatic model_edge(input logic r, input logic v, input logic [1:0] op,
                            input logic [CNT_W-1:0] cnt);
    bit   acc;
    cmd_t c;
    if (r) begin
      mq.delete(); left = 0; mj = 1'b0; mk = 1'b0; md = 1'b0; mqp = 1'b0;
      return;
    end
    if ({mj, mk} == 2'b01) mqp = 1'b0;
    else if ({mj, mk} == 2'b10) mqp = 1'b1;
    else if ({mj, mk} == 2'b11) mqp = ~mqp;
    acc = v && (mq.size() < DEPTH);
    md  = 1'b0;
    if (left > 1) begin
      left = left - 1;
      md   = (left == 1);
    end else if (mq.size() > 0) begin
      c    = mq.pop_front();
      left = int'(c.cnt);
      {mj, mk} = (c.cnt == 0) ? 2'b00 : c.op;
      md   = (c.cnt <= 1);
    end else begin
      left = 0; mj = 1'b0; mk = 1'b0;
    end
    if (acc) mq.push_back({op, cnt});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // one clock: drive, edge, advance model, settle
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [CNT_W-1:0] cnt);
    rst = r; cmd_valid = v; cmd_op = op; cmd_cnt = cnt;
    #1;
    hs = v && cmd_ready && !r;
    @(posedge clk);
    model_edge(r, v, op, cnt);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".j"}, 32'(j), 32'(mj));
    chk({tag, ".k"}, 32'(k), 32'(mk));
    chk({tag, ".done"}, 32'(done), 32'(md));
    chk({tag, ".busy"}, 32'(busy), 32'((left > 0) || (mq.size() > 0)));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".q_pred"}, 32'(q_pred), 32'(mqp));
`ifdef JKSEQ_CHECK_EN
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(0));
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic r, v; logic [1:0] op; logic [CNT_W-1:0] cnt;
    logic ej, ek, ed, eb, er, eq;
  } vec_t;
  vec_t tbl[10];

  logic exp_j[8], exp_k[8], exp_d[8], exp_q[8];

  initial begin
    int acc_step;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = '0;

    // single set then a zero-count toggle, then reset
    tbl[0] = '{1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'b10, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].cnt);
      chk($sformatf("tbl%0d.j", i),      32'(j),         32'(tbl[i].ej));
      chk($sformatf("tbl%0d.k", i),      32'(k),         32'(tbl[i].ek));
      chk($sformatf("tbl%0d.done", i),   32'(done),      32'(tbl[i].ed));
      chk($sformatf("tbl%0d.busy", i),   32'(busy),      32'(tbl[i].eb));
      chk($sformatf("tbl%0d.ready", i),  32'(cmd_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d.q_pred", i), 32'(q_pred),    32'(tbl[i].eq));
    end

    // reset in the 3rd issue cycle of a 5-cycle set
    step(1'b1, 1'b0, 2'b00, 4'd0);
    step(1'b0, 1'b1, 2'b10, 4'd5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 4'd0);
    chk("midrst.pre_j", 32'(j), 32'(1));
    chk("midrst.pre_q", 32'(q_pred), 32'(1));
    step(1'b1, 1'b0, 2'b00, 4'd0);
    chk("midrst.j", 32'(j), 32'(0));
    chk("midrst.k", 32'(k), 32'(0));
    chk("midrst.q_pred", 32'(q_pred), 32'(0));
    chk("midrst.busy", 32'(busy), 32'(0));
    chk("midrst.ready", 32'(cmd_ready), 32'(1));

    // back-to-back toggle x4 then clear x2 with no bubble
    exp_j = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_k = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    step(1'b1, 1'b0, 2'b00, 4'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      step(1'b0, 1'b1, 2'b11, 4'd4);
      else if (i == 1) step(1'b0, 1'b1, 2'b01, 4'd2);
      else             step(1'b0, 1'b0, 2'b00, 4'd0);
      chk($sformatf("b2b%0d.j", i),    32'(j),      32'(exp_j[i]));
      chk($sformatf("b2b%0d.k", i),    32'(k),      32'(exp_k[i]));
      chk($sformatf("b2b%0d.done", i), 32'(done),   32'(exp_d[i]));
      chk($sformatf("b2b%0d.q", i),    32'(q_pred), 32'(exp_q[i]));
      check_model($sformatf("b2b%0d", i));
    end

    // full FIFO: one issuing + four queued, fifth held until a pop frees a slot
    step(1'b1, 1'b0, 2'b00, 4'd0);
    done_seen = 0;
    step(1'b0, 1'b1, 2'b10, 4'd15);
    step(1'b0, 1'b1, 2'b11, 4'd15);
    step(1'b0, 1'b1, 2'b01, 4'd15);
    step(1'b0, 1'b1, 2'b00, 4'd15);
    step(1'b0, 1'b1, 2'b11, 4'd15);
    chk("full.ready", 32'(cmd_ready), 32'(0));
    check_model("full.q4");
    acc_step = -1;
    for (int i = 5; i < 60 && acc_step < 0; i++) begin
      step(1'b0, 1'b1, 2'b10, 4'd2);
      if (hs) acc_step = i;
      check_model($sformatf("full.s%0d", i));
    end
    chk("full.accept_step", 32'(acc_step), 32'(17));
    n = 0;
    while (busy === 1'b1 && n < 150) begin
      step(1'b0, 1'b0, 2'b00, 4'd0);
      check_model("full.drain");
      n++;
    end
    chk("full.drained", 32'(busy), 32'(0));
    chk("full.done_count", 32'(done_seen), 32'(6));

`ifdef JKSEQ_CHECK_EN
    // feedback check: clean run, one corrupted cycle, sticky until reset
    step(1'b1, 1'b0, 2'b00, 4'd0);
    step(1'b0, 1'b1, 2'b11, 4'd5);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'b00, 4'd0);
    chk("chk.clean", 32'(mismatch), 32'(0));
    inj = 1'b1;
    step(1'b0, 1'b0, 2'b00, 4'd0);
    inj = 1'b0;
    chk("chk.set", 32'(mismatch), 32'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 4'd0);
    chk("chk.sticky", 32'(mismatch), 32'(1));
    step(1'b1, 1'b0, 2'b00, 4'd0);
    chk("chk.rst", 32'(mismatch), 32'(0));
`endif

    // random traffic against the model
    step(1'b1, 1'b0, 2'b00, 4'd0);
    for (int i = 0; i < 3000; i++) begin
      logic             r, v;
      logic [1:0]       op;
      logic [CNT_W-1:0] cnt;
      r   = ($urandom_range(0, 99) == 0);
      v   = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      cnt = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 15))
                                        : CNT_W'($urandom_range(0, 2));
      step(r, v, op, cnt);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
